// File: rtl/fu_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module      : fu_wb_arbiter
// Description : Round-robin writeback arbiter. Each functional-unit result
//               channel owns a small circular FIFO. The head entries are
//               arbitrated onto a single scoreboard writeback port. A grant
//               that meets backpressure is locked until it is accepted.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fu_wb_arbiter #(
  parameter int unsigned NrChannels   = 4,
  parameter int unsigned FifoDepth    = 2,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned TransIdWidth = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NrChannels-1:0]              ch_valid_i,
  output logic [NrChannels-1:0]              ch_ready_o,
  input  logic [NrChannels*DataWidth-1:0]    ch_result_i,
  input  logic [NrChannels*TransIdWidth-1:0] ch_trans_id_i,
  input  logic [NrChannels-1:0]              ch_ex_i,
  output logic                               wb_valid_o,
  input  logic                               wb_ready_i,
  output logic [DataWidth-1:0]               wb_result_o,
  output logic [TransIdWidth-1:0]            wb_trans_id_o,
  output logic                               wb_ex_o,
  output logic [$clog2(NrChannels)-1:0]      wb_channel_o
);

  localparam int unsigned CH_W    = $clog2(NrChannels);
  // A single-entry buffer still needs a 1-bit pointer to stay legal.
  localparam int unsigned PTR_W   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CNT_W   = $clog2(FifoDepth + 1);
  localparam int unsigned ENTRY_W = DataWidth + TransIdWidth + 1;

  logic [NrChannels-1:0] nonempty;
  logic [NrChannels-1:0] push;
  logic [NrChannels-1:0] pop;
  logic [ENTRY_W-1:0]    heads [NrChannels];

  logic                  locked;
  logic [CH_W-1:0]       lock_ch;
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       search_ch;
  logic [CH_W-1:0]       grant;
  logic                  found;
  logic [CH_W:0]         idx;
  logic                  accept;
  logic [ENTRY_W-1:0]    head;

  // Circular pointer advance, wrapping at the last buffer slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept = wb_valid_o & wb_ready_i;

  for (genvar i = 0; i < NrChannels; i++) begin : g_ch
    logic [ENTRY_W-1:0] mem [FifoDepth];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;

    // Ready depends on the current count only, so a pop cannot free a slot
    // for a push in the same cycle.
    assign full          = (count == CNT_W'(FifoDepth));
    assign ch_ready_o[i] = ~full;
    assign nonempty[i]   = (count != '0);
    assign push[i]       = ch_valid_i[i] & ~full & ~flush_i;
    assign pop[i]        = accept & (grant == CH_W'(i)) & ~flush_i;
    assign heads[i]      = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (flush_i) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[i]) wr_ptr <= ptr_inc(wr_ptr);
        if (pop[i])  rd_ptr <= ptr_inc(rd_ptr);
        if (push[i] && !pop[i])      count <= count + 1'b1;
        else if (!push[i] && pop[i]) count <= count - 1'b1;
      end
    end

    // Result storage: {ex, trans_id, result}; contents need no reset.
    always_ff @(posedge clk_i) begin
      if (push[i]) begin
        mem[wr_ptr] <= {ch_ex_i[i],
                        ch_trans_id_i[i*TransIdWidth +: TransIdWidth],
                        ch_result_i[i*DataWidth +: DataWidth]};
      end
    end
  end

  // First non-empty channel at or after rr_ptr, wrapping round.
  always_comb begin
    found     = 1'b0;
    search_ch = '0;
    idx       = '0;
    for (int k = 0; k < NrChannels; k++) begin
      idx = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NrChannels)) idx = idx - (CH_W+1)'(NrChannels);
      if (!found && nonempty[idx[CH_W-1:0]]) begin
        found     = 1'b1;
        search_ch = idx[CH_W-1:0];
      end
    end
  end

  assign grant      = locked ? lock_ch : search_ch;
  assign wb_valid_o = |nonempty;
  assign head       = heads[grant];

  // Outputs are forced to zero whenever nothing is offered.
  assign wb_result_o   = wb_valid_o ? head[DataWidth-1:0] : '0;
  assign wb_trans_id_o = wb_valid_o ? head[DataWidth +: TransIdWidth] : '0;
  assign wb_ex_o       = wb_valid_o & head[ENTRY_W-1];
  assign wb_channel_o  = wb_valid_o ? grant : '0;

  // Grant lock under backpressure and round-robin pointer update on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked  <= 1'b0;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else if (flush_i) begin
      locked  <= 1'b0;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else if (wb_valid_o && !wb_ready_i) begin
      locked  <= 1'b1;
      lock_ch <= grant;
    end else if (accept) begin
      locked  <= 1'b0;
      rr_ptr  <= (grant == CH_W'(NrChannels - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fu_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_fu_wb_arbiter
// Description : Self-checking bench for fu_wb_arbiter. A directed vector table
//               covers reset, round-robin order, grant lock, the full-buffer
//               boundary, flush and asynchronous reset. A random phase then
//               checks per-channel ordering against reference queues.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fu_wb_arbiter;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int DW = 64;
  localparam int TW = 3;
  localparam int NV = 35;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic [N-1:0]    ch_valid_i;
  logic [N-1:0]    ch_ready_o;
  logic [N*DW-1:0] ch_result_i;
  logic [N*TW-1:0] ch_trans_id_i;
  logic [N-1:0]    ch_ex_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [DW-1:0]   wb_result_o;
  logic [TW-1:0]   wb_trans_id_o;
  logic            wb_ex_o;
  logic [1:0]      wb_channel_o;

  fu_wb_arbiter #(
    .NrChannels(N), .FifoDepth(D), .DataWidth(DW), .TransIdWidth(TW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
    .ch_result_i(ch_result_i), .ch_trans_id_i(ch_trans_id_i), .ch_ex_i(ch_ex_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_ex_o(wb_ex_o), .wb_channel_o(wb_channel_o)
  );

  always #5 clk_i = ~clk_i;

  // One row = inputs for a cycle + outputs expected in that same cycle.
  typedef struct {
    logic       rst_n;
    logic       flush;
    logic [3:0] valid;
    logic [11:0] tids;   // {ch3, ch2, ch1, ch0}, 3 bits each (octal digits)
    logic [3:0] ex;
    logic       rdy;
    logic       ev;
    logic [1:0] ech;
    logic [2:0] etid;
    logic       eex;
    logic [3:0] erdy;
  } vec_t;

  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_err = 0;

  logic [67:0] q [N][$];
  logic [3:0]  exp_rdy;
  logic        any_q;
  int          prev_lock;

  function automatic logic [63:0] data_of(input int ch, input logic [2:0] tid);
    return 64'hD00D_0000_0000_0000 | (64'(ch) << 8) | 64'(tid);
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic flush,
                              input logic [3:0] valid, input logic [11:0] tids,
                              input logic [3:0] ex, input logic rdy,
                              input logic ev, input logic [1:0] ech,
                              input logic [2:0] etid, input logic eex,
                              input logic [3:0] erdy);
    vec_t v;
    v.rst_n = rst_n; v.flush = flush; v.valid = valid; v.tids = tids;
    v.ex = ex; v.rdy = rdy; v.ev = ev; v.ech = ech; v.etid = etid;
    v.eex = eex; v.erdy = erdy;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_ni     = v.rst_n;
    flush_i    = v.flush;
    ch_valid_i = v.valid;
    ch_ex_i    = v.ex;
    wb_ready_i = v.rdy;
    for (int i = 0; i < N; i++) begin
      ch_trans_id_i[i*TW +: TW] = v.tids[i*3 +: 3];
      ch_result_i[i*DW +: DW]   = data_of(i, v.tids[i*3 +: 3]);
    end
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; ch_valid_i = '0; ch_ex_i = '0;
    wb_ready_i = 1'b0; ch_result_i = '0; ch_trans_id_i = '0;

    //              rst   flush valid   tids     ex      rdy  | ev   ech   etid  eex   erdy
    // reset, then round-robin over a 4-channel burst
    vecs[0]  = mk(1'b0, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[1]  = mk(1'b1, 1'b0, 4'b1111, 12'o3210, 4'b1010, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[2]  = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[3]  = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd1, 3'd1, 1'b1, 4'hF);
    vecs[4]  = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd2, 3'd2, 1'b0, 4'hF);
    vecs[5]  = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd3, 3'd3, 1'b1, 4'hF);
    vecs[6]  = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    // ch2 locked for 5 stalled cycles while ch0, ch1 fill; then 2,0,1
    vecs[7]  = mk(1'b1, 1'b0, 4'b0100, 12'o0500, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[8]  = mk(1'b1, 1'b0, 4'b0001, 12'o0006, 4'b0001, 1'b0, 1'b1, 2'd2, 3'd5, 1'b0, 4'hF);
    vecs[9]  = mk(1'b1, 1'b0, 4'b0010, 12'o0070, 4'b0000, 1'b0, 1'b1, 2'd2, 3'd5, 1'b0, 4'hF);
    vecs[10] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b0, 1'b1, 2'd2, 3'd5, 1'b0, 4'hF);
    vecs[11] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b0, 1'b1, 2'd2, 3'd5, 1'b0, 4'hF);
    vecs[12] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b0, 1'b1, 2'd2, 3'd5, 1'b0, 4'hF);
    vecs[13] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd2, 3'd5, 1'b0, 4'hF);
    vecs[14] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd0, 3'd6, 1'b1, 4'hF);
    vecs[15] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd1, 3'd7, 1'b0, 4'hF);
    vecs[16] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    // ch1 full boundary: third push refused, no pop-to-push pass-through
    vecs[17] = mk(1'b1, 1'b0, 4'b0010, 12'o0010, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[18] = mk(1'b1, 1'b0, 4'b0010, 12'o0020, 4'b0000, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 4'hF);
    vecs[19] = mk(1'b1, 1'b0, 4'b0010, 12'o0030, 4'b0000, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 4'b1101);
    vecs[20] = mk(1'b1, 1'b0, 4'b0010, 12'o0040, 4'b0000, 1'b1, 1'b1, 2'd1, 3'd1, 1'b0, 4'b1101);
    vecs[21] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd1, 3'd2, 1'b0, 4'hF);
    vecs[22] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    // flush with ch0 full and ch3 locked; afterwards rr_ptr restarts at 0
    vecs[23] = mk(1'b1, 1'b0, 4'b1001, 12'o3001, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[24] = mk(1'b1, 1'b0, 4'b0001, 12'o0002, 4'b0000, 1'b0, 1'b1, 2'd3, 3'd3, 1'b0, 4'hF);
    vecs[25] = mk(1'b1, 1'b1, 4'b0010, 12'o0050, 4'b0000, 1'b1, 1'b1, 2'd3, 3'd3, 1'b0, 4'b1110);
    vecs[26] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[27] = mk(1'b1, 1'b0, 4'b1010, 12'o4060, 4'b1000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[28] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd1, 3'd6, 1'b0, 4'hF);
    vecs[29] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b1, 2'd3, 3'd4, 1'b1, 4'hF);
    vecs[30] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    // asynchronous reset with all buffers occupied; no stale result after it
    vecs[31] = mk(1'b1, 1'b0, 4'b1111, 12'o7777, 4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[32] = mk(1'b0, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[33] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);
    vecs[34] = mk(1'b1, 1'b0, 4'b0000, 12'o0000, 4'b0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 4'hF);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      drive(vecs[i]);
      #1;
      n_vec++;
      check("wb_valid",    i, 128'(wb_valid_o),    128'(vecs[i].ev));
      check("wb_channel",  i, 128'(wb_channel_o),  128'(vecs[i].ev ? vecs[i].ech : 2'd0));
      check("wb_trans_id", i, 128'(wb_trans_id_o), 128'(vecs[i].ev ? vecs[i].etid : 3'd0));
      check("wb_ex",       i, 128'(wb_ex_o),       128'(vecs[i].ev & vecs[i].eex));
      check("wb_result",   i, 128'(wb_result_o),
            128'(vecs[i].ev ? data_of(int'(vecs[i].ech), vecs[i].etid) : 64'd0));
      check("ch_ready",    i, 128'(ch_ready_o),    128'(vecs[i].erdy));
    end

    // Random traffic against per-channel reference queues, then a drain.
    prev_lock = -1;
    for (int c = 0; c < 10040; c++) begin
      @(negedge clk_i);
      rst_ni  = 1'b1;
      flush_i = 1'b0;
      if (c < 10000) begin
        ch_valid_i = 4'($urandom);
        wb_ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        ch_valid_i = '0;
        wb_ready_i = 1'b1;
      end
      ch_ex_i = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        ch_trans_id_i[i*TW +: TW] = 3'($urandom);
        ch_result_i[i*DW +: DW]   = {$urandom, $urandom};
      end
      #1;
      n_vec++;
      any_q = 1'b0;
      for (int i = 0; i < N; i++) begin
        exp_rdy[i] = (q[i].size() != D);
        if (q[i].size() != 0) any_q = 1'b1;
      end
      check("rnd_ready", c, 128'(ch_ready_o), 128'(exp_rdy));
      check("rnd_valid", c, 128'(wb_valid_o), 128'(any_q));
      if (prev_lock >= 0) check("rnd_lock", c, 128'(wb_channel_o), 128'(prev_lock));
      if (wb_valid_o) begin
        if (q[wb_channel_o].size() != 0)
          check("rnd_entry", c, 128'({wb_ex_o, wb_trans_id_o, wb_result_o}),
                128'(q[wb_channel_o][0]));
        else
          check("rnd_empty_ch", c, 128'(q[wb_channel_o].size()), 128'(1));
      end
      prev_lock = (wb_valid_o && !wb_ready_i) ? int'(wb_channel_o) : -1;
      if (wb_valid_o && wb_ready_i && q[wb_channel_o].size() != 0)
        void'(q[wb_channel_o].pop_front());
      for (int i = 0; i < N; i++) begin
        if (ch_valid_i[i] && exp_rdy[i])
          q[i].push_back({ch_ex_i[i], ch_trans_id_i[i*TW +: TW], ch_result_i[i*DW +: DW]});
      end
    end
    for (int i = 0; i < N; i++) check("drain_left", i, 128'(q[i].size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fu_wb_arbiter.md
# fu_wb_arbiter

Parametrised writeback arbiter for the execute stage. It collects results from `NrChannels` functional-unit result channels into one scoreboard writeback port. Examples are the multiplier, the CSR buffer, accelerator ports and future extra FLU channels. Each channel gets a `FifoDepth`-entry result buffer. Arbitration is round-robin, so a stalled writeback port no longer forces every unit to serialise through a single-entry slot. Sits between the functional units and the scoreboard write port.

## Interface
- `NrChannels`, 4, number of result channels; legal range ≥2.
- `FifoDepth`, 2, entries per channel buffer; legal range ≥1, any value.
- `DataWidth`, 64, result width (`riscv::XLEN`).
- `TransIdWidth`, 3, scoreboard transaction ID width (`TRANS_ID_BITS`).
- `clk_i`, input, 1, clock.
- `rst_ni`, input, 1, reset, asynchronous, active-low.
- `flush_i`, input, 1, synchronous flush: discards all buffered results.
- `ch_valid_i`, input, NrChannels, per-channel result valid.
- `ch_ready_o`, output, NrChannels, per-channel buffer not full.
- `ch_result_i`, input, NrChannels×DataWidth, per-channel result.
- `ch_trans_id_i`, input, NrChannels×TransIdWidth, per-channel transaction ID.
- `ch_ex_i`, input, NrChannels, per-channel exception-valid flag.
- `wb_valid_o`, output, 1, writeback valid.
- `wb_ready_i`, input, 1, scoreboard accepts writeback.
- `wb_result_o`, output, DataWidth, granted result.
- `wb_trans_id_o`, output, TransIdWidth, granted transaction ID.
- `wb_ex_o`, output, 1, granted exception flag.
- `wb_channel_o`, output, $clog2(NrChannels), index of the granted channel.

## Operation
- **Per-channel buffer:** a circular FIFO with read/write pointers wrapping `FifoDepth-1`→0 and a count of width $clog2(FifoDepth+1).
  - `ch_ready_o[i] = (count_i != FifoDepth)`.
  - A push on channel i occurs when `ch_valid_i[i] & ch_ready_o[i] & ~flush_i`.
  - `ch_valid_i` while not ready is ignored; the producer must hold.
- **Full-buffer rule:** when a channel's buffer is full, ready stays 0 for that cycle even if it is popped in the same cycle. There is no pop-to-push pass-through.
- **Simultaneous push and pop** on a non-full, non-empty buffer: count is unchanged and both pointers advance.
- **Arbitration:**
  - `wb_valid_o` = OR of non-empty buffers.
  - When no grant is locked, the grant goes to the first non-empty channel searching from `rr_ptr`, wrapping at `NrChannels-1`→0.
- **Grant lock:** if `wb_valid_o & ~wb_ready_i`, the current grant is registered as locked. Channel, result, trans ID and ex flag stay stable until accepted, even if lower-index-from-pointer channels fill.
- **Pop:** on `wb_valid_o & wb_ready_i`, the head of the granted channel is popped, the lock is cleared and `rr_ptr` ← granted+1 (wrap).
- **Output silencing:** when `wb_valid_o`=0, `wb_result_o`, `wb_trans_id_o`, `wb_ex_o` and `wb_channel_o` drive 0.
- **Flush:**
  - The next state is all counts 0, pointers 0, lock cleared and `rr_ptr`=0.
  - Pushes and the pop in the flush cycle are discarded.
  - Outputs in the flush cycle still reflect pre-flush state; the scoreboard ignores them during flush.

## Timing
- **Reset values:**
  - `wb_valid_o`=0 and all `wb_*` outputs =0.
  - `ch_ready_o` all 1, since buffers are empty.
  - `rr_ptr`=0 and no lock.
- **Latency:** a push at edge t is visible on `wb_valid_o` after edge t; there is no same-cycle bypass. Minimum input-to-writeback latency is 1 cycle.
- **Throughput:** 1 writeback per cycle aggregate. Each channel sustains 1 per cycle when `FifoDepth`≥2, or 1 every 2 cycles when `FifoDepth`=1.
- **Reset mid-operation:** asynchronous clear of all state; outputs return to reset values immediately.
- **Fairness:** with all channels continuously non-empty and `wb_ready_i`=1, grants cycle 0,1,…,N-1,0. No channel waits more than N-1 accepted writebacks.

## Test plan
- **Reset and idle:** assert `rst_ni`=0 mid-burst with buffers occupied → `wb_valid_o`=0, all `ch_ready_o`=1; after release, no stale result appears.
- **Round-robin:** N=4, depth 2, pulse ch0..ch3 valid in one cycle with trans IDs 0..3, `wb_ready_i`=1 → writebacks with `wb_channel_o` 0,1,2,3 on 4 consecutive cycles, starting 1 cycle after the push.
- **Backpressure lock:** ch2 pending, `wb_ready_i`=0 for 5 cycles while ch0 and ch1 push → `wb_channel_o`=2 with data stable all 5 cycles; after ready, order is 2,0,1 (rr_ptr=3 wraps to 0).
- **Full boundary:** depth 2, ch1 pushes 3 consecutive cycles with `wb_ready_i`=0 → `ch_ready_o[1]`=0 from cycle 2; the third push is not accepted. Pop one with ready=1 → ready is still 0 that cycle and 1 the next.
- **Flush:** fill ch0 with 2 entries and ch3 with 1, then assert `flush_i` together with a ch1 push → next cycle `wb_valid_o`=0 and all ready =1; a following ch3 push is granted first (rr_ptr=0 search reaches ch3).
- **Data integrity:** random valid/ready over 10k cycles, compared against a per-channel reference queue model → every result, trans ID and ex flag is delivered exactly once and in order within each channel.
